// File: rtl/lfsr_pkg.sv
// Shared LFSR constants: maximal XNOR Fibonacci tap masks and the default seed.
// Used by lfsr_prbs_gen (optional lockup recovery under LFSR_LOCKUP_DET_EN).
package lfsr_pkg;

    localparam logic [3:0]  LFSR4_TAPS  = 4'hC;
    localparam logic [6:0]  LFSR7_TAPS  = 7'h60;
    localparam logic [14:0] LFSR15_TAPS = 15'h6000;
    localparam logic [21:0] LFSR22_TAPS = 22'h300000;

    // All-ones is the XNOR lockup state, so the default seed must avoid it.
    localparam logic [21:0] LFSR_DEFAULT_SEED = 22'h000001;

endpackage

// File: rtl/lfsr_leap.sv
// Combinational leap-forward: applies SYM_BITS single XNOR Fibonacci shifts in one step.
// The first generated bit ends up at bit SYM_BITS-1, the newest at bit 0.
module lfsr_leap
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 22,
    parameter logic [WIDTH-1:0] TAPS     = LFSR22_TAPS,
    parameter int               SYM_BITS = 4
) (
    input  logic [WIDTH-1:0] state_in,
    output logic [WIDTH-1:0] state_out
);

    logic [WIDTH-1:0] s;

    always_comb begin
        s = state_in;
        for (int i = 0; i < SYM_BITS; i++) begin
            s = {s[WIDTH-2:0], ~^(s & TAPS)};
        end
        state_out = s;
    end

endmodule

// File: rtl/lfsr_prbs_gen.sv
// PRBS symbol source: registered LFSR state, seed/start register, wrap detect.
// Define LFSR_LOCKUP_DET_EN to enable all-ones lockup detection and recovery to SEED.
module lfsr_prbs_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 22,
    parameter logic [WIDTH-1:0] TAPS     = LFSR22_TAPS,
    parameter int               SYM_BITS = 4,
    parameter logic [WIDTH-1:0] SEED     = LFSR_DEFAULT_SEED
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed_in,
    output logic [WIDTH-1:0]    seq_out,
    output logic [SYM_BITS-1:0] sym_out,
    output logic                sym_valid,
    output logic                wrap,
    output logic                lock_err
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] leap_state;

    lfsr_leap #(
        .WIDTH    (WIDTH),
        .TAPS     (TAPS),
        .SYM_BITS (SYM_BITS)
    ) u_leap (
        .state_in  (state_q),
        .state_out (leap_state)
    );

`ifdef LFSR_LOCKUP_DET_EN
    localparam logic [WIDTH-1:0] LOCKUP_STATE = '1;

    logic lock_err_q;
    logic lockup;

    assign lockup = (state_q == LOCKUP_STATE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_err_q <= 1'b0;
        end else begin
            lock_err_q <= lockup && !seed_load;
        end
    end

    assign lock_err = lock_err_q;
`else
    assign lock_err = 1'b0;
`endif

    // Recovery rewrites only the state; start_q keeps the last loaded seed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SEED;
            start_q   <= SEED;
            sym_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            sym_valid <= 1'b0;
            wrap      <= 1'b0;
            if (seed_load) begin
                state_q <= seed_in;
                start_q <= seed_in;
`ifdef LFSR_LOCKUP_DET_EN
            end else if (lockup) begin
                state_q <= SEED;
`endif
            end else if (clk_en) begin
                state_q   <= leap_state;
                sym_valid <= 1'b1;
                wrap      <= (leap_state == start_q);
            end
        end
    end

    assign seq_out = state_q;
    assign sym_out = state_q[SYM_BITS-1:0];

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Directed bench for lfsr_prbs_gen on the 4-bit maximal polynomial (TAPS=4'hC, SEED=0).
// Expectations follow LFSR_LOCKUP_DET_EN when it is defined for the build.
module tb_lfsr_prbs_gen;
    import lfsr_pkg::*;

    logic       clk = 1'b0;
    logic       reset;

    logic       en1, ld1;
    logic [3:0] din1, seq1;
    logic [0:0] sym1;
    logic       v1, w1, l1;

    logic       en2, ld2;
    logic [3:0] din2, seq2;
    logic [1:0] sym2;
    logic       v2, w2, l2;

    always #5 clk = ~clk;

    lfsr_prbs_gen #(
        .WIDTH(4), .TAPS(LFSR4_TAPS), .SYM_BITS(1), .SEED(4'h0)
    ) u_dut1 (
        .clk(clk), .reset(reset), .clk_en(en1), .seed_load(ld1), .seed_in(din1),
        .seq_out(seq1), .sym_out(sym1), .sym_valid(v1), .wrap(w1), .lock_err(l1)
    );

    lfsr_prbs_gen #(
        .WIDTH(4), .TAPS(LFSR4_TAPS), .SYM_BITS(2), .SEED(4'h0)
    ) u_dut2 (
        .clk(clk), .reset(reset), .clk_en(en2), .seed_load(ld2), .seed_in(din2),
        .seq_out(seq2), .sym_out(sym2), .sym_valid(v2), .wrap(w2), .lock_err(l2)
    );

    typedef struct {
        logic       en;
        logic       ld;
        logic [3:0] din;
        logic [3:0] seq;
        logic       valid;
        logic       wrap;
        logic       lock;
    } vec_t;

    vec_t tbl [64];
    int   n_vec = 0;
    int   pass_cnt = 0;
    int   chk_cnt = 0;
    int   early_wraps;

    // Hand-derived orbit of the 4-bit XNOR LFSR starting from 0.
    logic [3:0] seq4 [15] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC,
                              4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};

    task automatic add(input logic en, input logic ld, input logic [3:0] din,
                       input logic [3:0] seq, input logic v, input logic w, input logic l);
        tbl[n_vec] = '{en, ld, din, seq, v, w, l};
        n_vec++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc1(input logic en, input logic ld, input logic [3:0] din);
        @(negedge clk);
        en1  = en;
        ld1  = ld;
        din1 = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        en1 = 1'b0; ld1 = 1'b0; din1 = 4'h0;
        en2 = 1'b0; ld2 = 1'b0; din2 = 4'h0;

        for (int i = 0; i < 15; i++) add(1'b1, 1'b0, 4'h0, seq4[i], 1'b1, (i == 14), 1'b0);
        add(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 4'h7, 4'h7, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) add(1'b1, 1'b0, 4'h0, seq4[(i + 3) % 15], 1'b1, (i == 14), 1'b0);
        add(1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
`ifdef LFSR_LOCKUP_DET_EN
        add(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0);
`else
        // start_q is F after the load, so every step back onto F reports a wrap.
        for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0);
`endif

        #1;
        check("rst_seq1", 32'(seq1), 32'h0);
        check("rst_valid1", 32'(v1), 32'h0);
        check("rst_wrap1", 32'(w1), 32'h0);
        check("rst_lock1", 32'(l1), 32'h0);
        check("rst_seq2", 32'(seq2), 32'h0);
        check("rst_sym2", 32'(sym2), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < n_vec; i++) begin
            cyc1(tbl[i].en, tbl[i].ld, tbl[i].din);
            check($sformatf("vec%0d_seq", i), 32'(seq1), 32'(tbl[i].seq));
            check($sformatf("vec%0d_sym", i), 32'(sym1), 32'(tbl[i].seq[0]));
            check($sformatf("vec%0d_valid", i), 32'(v1), 32'(tbl[i].valid));
            check($sformatf("vec%0d_wrap", i), 32'(w1), 32'(tbl[i].wrap));
            check($sformatf("vec%0d_lock", i), 32'(l1), 32'(tbl[i].lock));
        end

        // Two-bit leap from 0: 0 -> 1 -> 3.
        @(negedge clk);
        en2 = 1'b1;
        @(posedge clk);
        #1;
        check("leap2_seq", 32'(seq2), 32'h3);
        check("leap2_sym", 32'(sym2), 32'h3);
        check("leap2_valid", 32'(v2), 32'h1);
        @(negedge clk);
        en2 = 1'b0;
        @(posedge clk);
        #1;
        check("hold2_seq", 32'(seq2), 32'h3);
        check("hold2_valid", 32'(v2), 32'h0);

        // Runtime seed 5, walk to B, then reset asynchronously between edges.
        cyc1(1'b0, 1'b1, 4'h5);
        check("load5_seq", 32'(seq1), 32'h5);
        for (int i = 0; i < 10; i++) cyc1(1'b1, 1'b0, 4'h0);
        check("pre_rst_seq", 32'(seq1), 32'hB);
        check("pre_rst_valid", 32'(v1), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_seq", 32'(seq1), 32'h0);
        check("async_sym", 32'(sym1), 32'h0);
        check("async_valid", 32'(v1), 32'h0);
        check("async_wrap", 32'(w1), 32'h0);
        check("async_lock", 32'(l1), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        en1 = 1'b0;

        // start_q must be back at SEED: no wrap when passing 5, wrap on the 15th step at 0.
        early_wraps = 0;
        for (int i = 0; i < 15; i++) begin
            cyc1(1'b1, 1'b0, 4'h0);
            check($sformatf("post_rst%0d_seq", i), 32'(seq1), 32'(seq4[i]));
            if (i < 14 && w1) early_wraps++;
        end
        check("post_rst_early_wraps", 32'(early_wraps), 32'h0);
        check("post_rst_wrap15", 32'(w1), 32'h1);
        @(negedge clk);
        en1 = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
